// File: rtl/ysyx_22050854_mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide sequencer: MULctr codes,
// FSM states and op-decode helper flags.
package ysyx_22050854_mdu_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned WLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] WLEN_MIN = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

  // MULctr encoding as emitted by decode
  localparam logic [3:0] OP_MUL    = 4'b0000;
  localparam logic [3:0] OP_MULH   = 4'b0001;
  localparam logic [3:0] OP_MULHSU = 4'b0010;
  localparam logic [3:0] OP_MULHU  = 4'b0011;
  localparam logic [3:0] OP_DIV    = 4'b0100;
  localparam logic [3:0] OP_DIVU   = 4'b0101;
  localparam logic [3:0] OP_REM    = 4'b0110;
  localparam logic [3:0] OP_REMU   = 4'b0111;
  localparam logic [3:0] OP_MULW   = 4'b1000;
  localparam logic [3:0] OP_NONE   = 4'b1001;
  localparam logic [3:0] OP_DIVW   = 4'b1100;
  localparam logic [3:0] OP_DIVUW  = 4'b1101;
  localparam logic [3:0] OP_REMW   = 4'b1110;
  localparam logic [3:0] OP_REMUW  = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  // 1001/1010/1011 carry no M-extension work
  function automatic logic is_none(input logic [3:0] op);
    return op[3] & ~op[2] & (op[1:0] != 2'b00);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [3:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_hi(input logic [3:0] op);
    return ~op[3] & ~op[2] & (op[1:0] != 2'b00);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return op[3];
  endfunction

  // mul/mulw only keep the low half, so they are treated as unsigned
  function automatic logic src1_signed(input logic [3:0] op);
    return op[2] ? ~op[0] : (~op[3] & ((op[1:0] == 2'b01) | (op[1:0] == 2'b10)));
  endfunction

  function automatic logic src2_signed(input logic [3:0] op);
    return op[2] ? ~op[0] : (~op[3] & (op[1:0] == 2'b01));
  endfunction

  function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22050854_mdu_iter.sv
// Single-step radix-2 datapath: shift-add multiply or restoring divide over
// a {hi, lo} accumulator, one step per cycle while step is high.
module ysyx_22050854_mdu_iter
  import ysyx_22050854_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            is_div,
  input  logic            is_word,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] acc_hi,
  output logic [XLEN-1:0] acc_lo
);

  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   shl;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] hi_n;
  logic [XLEN-1:0] lo_n;

  // Next accumulator: mul adds multiplicand on lo[0] then shifts right,
  // div shifts left and keeps the trial subtraction when it does not borrow
  always_comb begin
    add_sum = {1'b0, acc_hi} + {1'b0, dvs_q};
    mul_sum = acc_lo[0] ? add_sum : {1'b0, acc_hi};
    shl     = {acc_hi, acc_lo[XLEN-1]};
    diff    = shl - {1'b0, dvs_q};
    hi_n    = mul_sum[XLEN:1];
    lo_n    = {mul_sum[0], acc_lo[XLEN-1:1]};
    if (is_div) begin
      if (diff[XLEN]) begin
        hi_n = shl[XLEN-1:0];
        lo_n = {acc_lo[XLEN-2:0], 1'b0};
      end else begin
        hi_n = diff[XLEN-1:0];
        lo_n = {acc_lo[XLEN-2:0], 1'b1};
      end
    end
  end

  // W divides pre-shift the 32-bit dividend to the top so 32 steps suffice
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi <= '0;
      acc_lo <= '0;
      dvs_q  <= '0;
    end else if (start) begin
      acc_hi <= '0;
      acc_lo <= (is_div && is_word) ? {op_a[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : op_a;
      dvs_q  <= op_b;
    end else if (step) begin
      acc_hi <= hi_n;
      acc_lo <= lo_n;
    end
  end

endmodule

// File: rtl/ysyx_22050854_mdu_ctrl.sv
// RV64M multiply/divide sequencer: accepts one MULctr op per handshake, runs
// the iterative datapath, applies sign/width fixups and holds the result.
module ysyx_22050854_mdu_ctrl
  import ysyx_22050854_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_e            state;
  state_e            state_n;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_lo_q;
  logic              neg_rem_q;
  logic              fast_q;
  logic [XLEN-1:0]   fast_res_q;

  logic              accept;
  logic              prep;
  logic              step;
  logic              res_load;
  logic [XLEN-1:0]   res_n;
  logic [XLEN-1:0]   src1_ext;
  logic [XLEN-1:0]   src2_ext;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              div_ovf;
  logic              fast;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN-1:0]   it_hi;
  logic [XLEN-1:0]   it_lo;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   fix_res;

  assign in_ready = (state == S_IDLE) && !flush && !rst;

  // W ops only see the low word, extended per the op's signedness
  always_comb begin
    src1_ext = src1;
    src2_ext = src2;
    if (is_word(op)) begin
      src1_ext = src1_signed(op) ? sext_w(src1[WLEN-1:0]) : {{(XLEN-WLEN){1'b0}}, src1[WLEN-1:0]};
      src2_ext = src2_signed(op) ? sext_w(src2[WLEN-1:0]) : {{(XLEN-WLEN){1'b0}}, src2[WLEN-1:0]};
    end
  end

  // Magnitudes, result signs and divide special cases from the latched op
  always_comb begin
    a_neg    = src1_signed(op_q) & a_q[XLEN-1];
    b_neg    = src2_signed(op_q) & b_q[XLEN-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    div_zero = (b_q == '0);
    div_ovf  = src1_signed(op_q) && (b_q == '1) &&
               (a_q == (is_word(op_q) ? WLEN_MIN : XLEN_MIN));
    fast     = is_div(op_q) && (div_zero || div_ovf);
    if (div_zero) begin
      fast_res = is_rem(op_q) ? (is_word(op_q) ? sext_w(a_q[WLEN-1:0]) : a_q) : '1;
    end else begin
      fast_res = is_rem(op_q) ? '0 : a_q;
    end
  end

  ysyx_22050854_mdu_iter u_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (prep),
    .step    (step),
    .is_div  (is_div(op_q)),
    .is_word (is_word(op_q)),
    .op_a    (a_mag),
    .op_b    (b_mag),
    .acc_hi  (it_hi),
    .acc_lo  (it_lo)
  );

  // Sign correction, hi/lo or quotient/remainder select, W sign-extension
  always_comb begin
    prod_s  = neg_lo_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    quo     = is_word(op_q) ? {{(XLEN-WLEN){1'b0}}, it_lo[WLEN-1:0]} : it_lo;
    quo_s   = neg_lo_q ? -quo : quo;
    rem_s   = neg_rem_q ? -it_hi : it_hi;
    div_sel = is_rem(op_q) ? rem_s : quo_s;
    if (fast_q) begin
      fix_res = fast_res_q;
    end else if (is_div(op_q)) begin
      fix_res = is_word(op_q) ? sext_w(div_sel[WLEN-1:0]) : div_sel;
    end else if (is_word(op_q)) begin
      fix_res = sext_w(it_lo[XLEN-1:XLEN-WLEN]);
    end else begin
      fix_res = is_hi(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    prep     = 1'b0;
    step     = 1'b0;
    res_load = 1'b0;
    res_n    = '0;
    unique case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_n = S_PREP;
        end
      end
      S_PREP: begin
        if (is_none(op_q)) begin
          res_load = 1'b1;
          state_n  = S_DONE;
        end else begin
          prep    = 1'b1;
          state_n = fast ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt_q == '0) state_n = S_FIX;
      end
      S_FIX: begin
        res_load = 1'b1;
        res_n    = fix_res;
        state_n  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (flush) begin
      state_n  = S_IDLE;
      accept   = 1'b0;
      res_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == S_DONE);
      busy      <= (state_n != S_IDLE);
      if (res_load) result <= res_n;
    end
  end

  // Operand latch at accept, fixup context at PREP, iteration countdown in CALC
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_NONE;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      neg_lo_q   <= 1'b0;
      neg_rem_q  <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= src1_ext;
        b_q  <= src2_ext;
      end
      if (prep) begin
        cnt_q      <= is_word(op_q) ? CNT_W'(WLEN - 1) : CNT_W'(XLEN - 1);
        neg_lo_q   <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
        fast_q     <= fast;
        fast_res_q <= fast_res;
      end else if (step && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_mdu_ctrl.sv
// Self-checking bench for the RV64M sequencer: directed cases plus random
// ops against a plain-arithmetic reference of the M-extension semantics.
module tb_ysyx_22050854_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] op_list [17] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                              4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                              4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0100};

  always #5 clk = ~clk;

  ysyx_22050854_mdu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Reference RV64M semantics using wide/native arithmetic
  function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    longint       sa;
    longint       sb;
    int           sa32;
    int           sb32;
    logic [31:0]  ua32;
    logic [31:0]  ub32;
    logic [31:0]  r32;
    logic [63:0]  r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    r = '0; r32 = '0;
    case (o)
      4'b0000: begin p = {64'd0, a} * {64'd0, b}; r = p[63:0]; end
      4'b0001: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      4'b0010: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      4'b0011: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      4'b0100: r = (b == 0) ? '1 : (a == 64'h8000_0000_0000_0000 && b == '1) ? a : 64'(sa / sb);
      4'b0101: r = (b == 0) ? '1 : a / b;
      4'b0110: r = (b == 0) ? a : (a == 64'h8000_0000_0000_0000 && b == '1) ? 64'd0 : 64'(sa % sb);
      4'b0111: r = (b == 0) ? a : a % b;
      4'b1000: begin r32 = ua32 * ub32; r = {{32{r32[31]}}, r32}; end
      4'b1100: begin
        r32 = (ub32 == 0) ? '1 : (ua32 == 32'h8000_0000 && ub32 == '1) ? ua32 : 32'(sa32 / sb32);
        r = {{32{r32[31]}}, r32};
      end
      4'b1101: begin r32 = (ub32 == 0) ? '1 : ua32 / ub32; r = {{32{r32[31]}}, r32}; end
      4'b1110: begin
        r32 = (ub32 == 0) ? ua32 : (ua32 == 32'h8000_0000 && ub32 == '1) ? 32'd0 : 32'(sa32 % sb32);
        r = {{32{r32[31]}}, r32};
      end
      4'b1111: begin r32 = (ub32 == 0) ? ua32 : ua32 % ub32; r = {{32{r32[31]}}, r32}; end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycle (after the accept edge) in which out_valid must first be seen
  function automatic int exp_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic zero;
    logic ovf;
    if (o[3] && !o[2] && o[1:0] != 2'b00) return 2;
    if (o[2]) begin
      zero = o[3] ? (b[31:0] == 32'd0) : (b == 64'd0);
      ovf  = !o[0] && (o[3] ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == 64'h8000_0000_0000_0000 && b == '1));
      if (zero || ovf) return 3;
    end
    return o[3] ? 35 : 67;
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [63:0] exp_r;
    int          exp_l;
    int          lat;
    int          busy_low;
    int          hold_bad;
    exp_r = model(o, a, b);
    exp_l = exp_lat(o, a, b);
    @(negedge clk);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    chk($sformatf("in_ready op%b", o), {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_low = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_low++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) busy_low++;
    chk($sformatf("latency op%b", o), 64'(lat), 64'(exp_l));
    chk($sformatf("result op%b a=%h b=%h", o, a, b), result, exp_r);
    chk($sformatf("busy op%b", o), 64'(busy_low), 64'd0);
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (result !== exp_r || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad++;
    end
    if (hold > 0) chk($sformatf("hold op%b", o), 64'(hold_bad), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("drain in_ready op%b", o), {63'd0, in_ready}, 64'd1);
    chk($sformatf("drain out_valid op%b", o), {63'd0, out_valid}, 64'd0);
  endtask

  task automatic abort_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic use_rst);
    int seen;
    @(negedge clk);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    #1;
    chk(use_rst ? "abort_rst in_ready" : "abort_flush in_ready", {63'd0, in_ready}, 64'd1);
    chk(use_rst ? "abort_rst busy" : "abort_flush busy", {63'd0, busy}, 64'd0);
    if (use_rst) chk("abort_rst result", result, 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    chk(use_rst ? "abort_rst out_valid" : "abort_flush out_valid", 64'(seen), 64'd0);
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return {32'h0, 32'h8000_0000};
      6: return 64'(-64'($urandom_range(1, 20)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'b1001; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {63'd0, in_ready}, 64'd1);

    run_op(4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    run_op(4'b0011, '1, '1, 0);
    run_op(4'b0001, '1, '1, 0);
    run_op(4'b1000, 64'h7FFF_FFFF, 64'd2, 0);
    run_op(4'b0100, 64'd7, 64'd0, 0);
    run_op(4'b0110, 64'd7, 64'd0, 0);
    run_op(4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    run_op(4'b1110, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    run_op(4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    run_op(4'b0101, 64'd100, 64'd7, 0);
    run_op(4'b0111, 64'd100, 64'd7, 5);
    run_op(4'b0100, 64'h8000_0000_0000_0000, '1, 1);
    run_op(4'b1001, 64'd5, 64'd6, 2);

    abort_op(4'b0100, 64'd1000, 64'd3, 1'b0);
    abort_op(4'b0100, 64'd1000, 64'd3, 1'b1);

    @(negedge clk);
    op = 4'b0100; src1 = 64'd9; src2 = 64'd2; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush+valid in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("flush+valid busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      run_op(op_list[$urandom_range(0, 16)], pick_val(), pick_val(), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
